mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//   Upstream controller for the 4:1 mux (S1,S0,D0..D3 -> Y). Steps the mux selects
//   through the enabled channels, waits a settle time per channel and samples Y.
//   It then publishes a 4-bit snapshot of D3..D0 with a one-cycle DONE pulse.
//   Supports single-shot scans (START pulse) and continuous back-to-back rescans (CONT).
// PARAMETERS
//   SETTLE_CYCLES  2  cycles S1/S0 are held before Y is sampled; legal range 1..15
//   CNT_W          8  width of SCAN_CNT
// PORTS
//   CLK       in   1      single clock; all logic on rising edge
//   RST       in   1      synchronous reset, active-high
//   START     in   1      scan request; sampled only in IDLE
//   CONT      in   1      1 = rescan immediately after each completed scan
//   MASK      in   4      channel enable, bit i enables Di; sampled at scan start
//   Y         in   1      mux output being scanned
//   S1        out  1      mux select MSB (registered)
//   S0        out  1      mux select LSB (registered)
//   BUSY      out  1      1 whenever state != IDLE
//   DONE      out  1      one-cycle pulse, scan complete, SNAP valid
//   SNAP      out  4      bit i = sampled Di; disabled channels read 0
//   SCAN_CNT  out  CNT_W  completed-scan count, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//   Reset: S1=S0=0, BUSY=0, DONE=0, SNAP=0, SCAN_CNT=0, shadow regs=0, state=IDLE.
//   States: IDLE, SETTLE, SAMPLE, FINISH.
//   IDLE:
//     - START=1 and MASK!=0: latch mask_q=MASK; ch = lowest set bit of mask_q.
//       Drive {S1,S0}=ch; settle counter = SETTLE_CYCLES-1; go to SETTLE.
//     - START=1 and MASK==0: ignored; stay in IDLE, no DONE.
//     - S1/S0 hold their last value.
//   SETTLE: decrement counter each cycle. At 0 -> SAMPLE. Dwell is exactly SETTLE_CYCLES cycles.
//   SAMPLE (one cycle): shadow[ch] <= Y.
//     - Next higher set bit of mask_q exists: ch = that bit, update S1/S0, reload counter, -> SETTLE.
//     - Otherwise -> FINISH.
//   FINISH (one cycle):
//     - SNAP <= shadow & mask_q; DONE=1; SCAN_CNT += 1. Shadow regs cleared.
//     - CONT=1: re-latch mask_q=MASK (if MASK==0 -> IDLE). Select lowest set bit, -> SETTLE.
//     - CONT=0: -> IDLE.
//   Timing: START sampled at edge t; k enabled channels. DONE is high in the cycle after
//     edge t + k*(SETTLE_CYCLES+1). Continuous period = k*(SETTLE_CYCLES+1)+1 cycles.
//   START while BUSY: ignored.
//   CONT or MASK changes mid-scan: no effect until FINISH.
//   RST mid-scan: reset values on the next edge; aborted scan gives no DONE; SNAP cleared.
//   DONE never asserts for two consecutive cycles.
// TESTING
//   1 Reset: RST=1 for 2 cycles -> S1S0=00, BUSY=0, DONE=0, SNAP=0000, SCAN_CNT=0.
//   2 Full scan: D3..D0=1010, MASK=1111, SETTLE=2, START at edge t.
//       -> S1S0 = 00,01,10,11, each held 3 cycles; DONE single pulse after edge t+12.
//       -> SNAP=1010, SCAN_CNT=1, BUSY low after DONE.
//   3 Masked: D=1111, MASK=0101 -> only selects 00 and 10 visited.
//       -> DONE after edge t+6, SNAP=0101.
//   4 Ignored requests:
//       - START with MASK=0000 -> BUSY stays 0, no DONE.
//       - Second START pulse mid-scan -> exactly one DONE.
//   5 Continuous: CONT=1, MASK=1111; D=0011 for scan 1, then 1100.
//       -> DONE every 13 cycles; SNAP=0011 then 1100.
//       - SCAN_CNT preloaded near 255 wraps 255->0.
//       - CONT dropped mid-scan -> that scan finishes, then IDLE.
//   6 Reset mid-scan: RST during SETTLE of ch2.
//       -> next cycle all outputs at reset values, no DONE.
//       -> new START afterwards scans normally.

Source files
------------

// File: rtl/mux_scan_if.sv
// Bus between the mux scan sequencer and its environment: request side, mux
// selects, sampled mux output and scan results.
interface mux_scan_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             cont;
    logic [3:0]       mask;
    logic             y;
    logic             s1;
    logic             s0;
    logic             busy;
    logic             done;
    logic [3:0]       snap;
    logic [CNT_W-1:0] scan_cnt;

    modport master (
        output start, cont, mask, y,
        input  s1, s0, busy, done, snap, scan_cnt
    );

    modport slave (
        input  start, cont, mask, y,
        output s1, s0, busy, done, snap, scan_cnt
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through the enabled channels, lets each select settle,
// samples Y, and publishes a snapshot of D3..D0 with a one-cycle done pulse.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic      clk,
    input  logic      rst,
    mux_scan_if.slave bus
);
    localparam int unsigned SETTLE_W    = 4;
    localparam int unsigned CH_W        = 2;
    localparam int unsigned NUM_CH      = 4;
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [NUM_CH-1:0]     shadow_q, shadow_d;
    logic [CH_W-1:0]       sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NUM_CH-1:0]     snap_q, snap_d;
    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [NUM_CH-1:0]     sampled;
    logic [CH_W:0]         nxt;

    // Lowest enabled channel of a non-zero mask.
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_W'(i);
        end
    endfunction

    // {found, channel} of the next enabled channel above cur.
    function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] m,
                                              input logic [CH_W-1:0]   cur);
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_ch = {1'b1, CH_W'(i)};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            shadow_q   <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            snap_q     <= '0;
            scan_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            shadow_q   <= shadow_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            snap_q     <= snap_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    // Next state and register updates; the last sample feeds the snapshot directly
    // so snap is valid in the same cycle done is high.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        shadow_d   = shadow_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
        snap_d     = snap_q;
        scan_cnt_d = scan_cnt_q;
        sampled    = shadow_q;
        sampled[ch_q] = bus.y;
        nxt        = next_ch(mask_q, ch_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.mask != '0)) begin
                    mask_d  = bus.mask;
                    ch_d    = lowest_ch(bus.mask);
                    sel_d   = lowest_ch(bus.mask);
                    cnt_d   = SETTLE_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (nxt[CH_W]) begin
                    shadow_d = sampled;
                    ch_d     = nxt[CH_W-1:0];
                    sel_d    = nxt[CH_W-1:0];
                    cnt_d    = SETTLE_INIT;
                    state_d  = ST_SETTLE;
                end else begin
                    shadow_d   = '0;
                    snap_d     = sampled & mask_q;
                    done_d     = 1'b1;
                    scan_cnt_d = scan_cnt_q + CNT_W'(1);
                    state_d    = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (bus.cont && (bus.mask != '0)) begin
                    mask_d  = bus.mask;
                    ch_d    = lowest_ch(bus.mask);
                    sel_d   = lowest_ch(bus.mask);
                    cnt_d   = SETTLE_INIT;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.s1       = sel_q[1];
    assign bus.s0       = sel_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.snap     = snap_q;
    assign bus.scan_cnt = scan_cnt_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a behavioural 4:1 mux closes the loop
// and every result is compared against hand-computed values.
module tb_mux_scan_sequencer;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERIOD = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d   = 4'b0000;
    int         checks = 0;
    int         errors = 0;

    mux_scan_if #(.CNT_W(CNT_W)) bus ();

    assign bus.y = d[{bus.s1, bus.s0}];

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Ticks at least once, then until done is seen or the budget runs out.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!bus.done && cycles < 100);
    endtask

    task automatic count_dones(input int n, output int dones, output logic [3:0] last_snap);
        dones = 0;
        last_snap = 4'b0000;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                last_snap = bus.snap;
            end
        end
    endtask

    initial begin
        int         lat;
        int         dones;
        int         bad;
        logic       early;
        logic [3:0] seen;
        logic [3:0] snap_v;

        bus.start = 1'b0;
        bus.cont  = 1'b0;
        bus.mask  = 4'b0000;

        // Reset
        tick();
        tick();
        check("rst_sel",  32'({bus.s1, bus.s0}), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_snap", 32'(bus.snap), 32'd0);
        check("rst_cnt",  32'(bus.scan_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Full scan, each select held three cycles
        d = 4'b1010;
        bus.mask = 4'b1111;
        pulse_start();
        early = 1'b0;
        for (int j = 0; j < 12; j++) begin
            check("full_sel", 32'({bus.s1, bus.s0}), 32'(j / 3));
            early |= bus.done;
            tick();
        end
        check("full_early_done", 32'(early), 32'd0);
        check("full_done", 32'(bus.done), 32'd1);
        check("full_snap", 32'(bus.snap), 32'b1010);
        check("full_cnt",  32'(bus.scan_cnt), 32'd1);
        tick();
        check("full_done_pulse", 32'(bus.done), 32'd0);
        check("full_busy_off",   32'(bus.busy), 32'd0);

        // Masked scan visits only channels 0 and 2
        d = 4'b1111;
        bus.mask = 4'b0101;
        pulse_start();
        seen = 4'b0000;
        lat = 0;
        do begin
            seen[{bus.s1, bus.s0}] = 1'b1;
            tick();
            lat++;
        end while (!bus.done && lat < 100);
        check("mask_lat",  32'(lat), 32'd6);
        check("mask_seen", 32'(seen), 32'b0101);
        check("mask_snap", 32'(bus.snap), 32'b0101);
        check("mask_cnt",  32'(bus.scan_cnt), 32'd2);
        tick();

        // Start with an empty mask is ignored
        bus.mask = 4'b0000;
        pulse_start();
        check("empty_busy", 32'(bus.busy), 32'd0);
        count_dones(20, dones, snap_v);
        check("empty_dones", 32'(dones), 32'd0);
        check("empty_cnt",   32'(bus.scan_cnt), 32'd2);

        // Second start mid-scan yields exactly one done
        d = 4'b0110;
        bus.mask = 4'b1111;
        pulse_start();
        repeat (4) tick();
        pulse_start();
        bus.mask = 4'b0001;
        count_dones(40, dones, snap_v);
        check("restart_dones", 32'(dones), 32'd1);
        check("restart_snap",  32'(snap_v), 32'b0110);
        check("restart_cnt",   32'(bus.scan_cnt), 32'd3);

        // Continuous scanning
        d = 4'b0011;
        bus.mask = 4'b1111;
        bus.cont = 1'b1;
        pulse_start();
        wait_done(lat);
        check("cont1_lat",  32'(lat), 32'd12);
        check("cont1_snap", 32'(bus.snap), 32'b0011);
        d = 4'b1100;
        wait_done(lat);
        check("cont2_lat",  32'(lat), 32'(PERIOD));
        check("cont2_snap", 32'(bus.snap), 32'b1100);
        check("cont2_cnt",  32'(bus.scan_cnt), 32'd5);

        bad = 0;
        for (int n = 0; n < 250; n++) begin
            wait_done(lat);
            if (lat != PERIOD) bad++;
        end
        check("cont_periods", 32'(bad), 32'd0);
        check("cont_cnt_max", 32'(bus.scan_cnt), 32'd255);
        wait_done(lat);
        check("cont_wrap_lat", 32'(lat), 32'(PERIOD));
        check("cont_wrap_cnt", 32'(bus.scan_cnt), 32'd0);

        // Dropping cont mid-scan lets that scan finish, then idle
        repeat (3) tick();
        bus.cont = 1'b0;
        wait_done(lat);
        check("drop_lat",  32'(lat), 32'd10);
        check("drop_cnt",  32'(bus.scan_cnt), 32'd1);
        tick();
        check("drop_busy", 32'(bus.busy), 32'd0);
        count_dones(30, dones, snap_v);
        check("drop_dones", 32'(dones), 32'd0);

        // Reset during settle of channel 2
        d = 4'b1111;
        pulse_start();
        repeat (6) tick();
        check("abort_sel", 32'({bus.s1, bus.s0}), 32'd2);
        rst = 1'b1;
        tick();
        check("abort_sel_rst", 32'({bus.s1, bus.s0}), 32'd0);
        check("abort_busy",    32'(bus.busy), 32'd0);
        check("abort_done",    32'(bus.done), 32'd0);
        check("abort_snap",    32'(bus.snap), 32'd0);
        check("abort_cnt",     32'(bus.scan_cnt), 32'd0);
        rst = 1'b0;
        count_dones(20, dones, snap_v);
        check("abort_dones", 32'(dones), 32'd0);

        // Normal scan after the abort
        d = 4'b0101;
        bus.mask = 4'b1111;
        pulse_start();
        wait_done(lat);
        check("post_lat",  32'(lat), 32'd12);
        check("post_snap", 32'(bus.snap), 32'b0101);
        check("post_cnt",  32'(bus.scan_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
